alu_checker: RTL and testbench

ALU_CHECKER -- requirements
Module: alu_checker

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_checker_if.sv | 15 +
 rtl/alu_chk_pipe.sv | 74 +++++++
 rtl/alu_checker.sv | 127 ++++++++++++
 tb/tb_alu_checker.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, checker FSM states and the golden reference model.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  // Widest ALU the reference model can describe; callers zero-extend operands.
  localparam int unsigned MaxW = 32;

  typedef enum logic {StRun, StHalt} chk_state_e;

  // Returns {c, y}: c in bit MaxW, y in bits [w-1:0] with all higher y bits zero.
  function automatic logic [MaxW:0] alu_ref(input logic [MaxW-1:0] a,
                                            input logic [MaxW-1:0] b,
                                            input logic [2:0]      sel,
                                            input int unsigned     w);
    logic [MaxW-1:0] mask;
    logic [MaxW-1:0] y;
    logic [MaxW:0]   ext;
    logic [MaxW:0]   shifted;
    logic [MaxW-1:0] msb_sh;
    logic            c;
    mask    = '1;
    mask    = mask >> (MaxW - w);
    ext     = '0;
    shifted = '0;
    msb_sh  = '0;
    y       = '0;
    c       = 1'b0;
    unique case (sel)
      ALU_ADD: begin
        ext     = {1'b0, a} + {1'b0, b};
        shifted = ext >> w;
        y       = ext[MaxW-1:0];
        c       = shifted[0];
      end
      ALU_SUB: begin
        // Operands are zero-extended, so a borrow sets every bit from w upwards.
        ext     = {1'b0, a} - {1'b0, b};
        shifted = ext >> w;
        y       = ext[MaxW-1:0];
        c       = shifted[0];
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOT: y = ~a;
      ALU_SHL: begin
        msb_sh = a >> (w - 1);
        y      = a << 1;
        c      = msb_sh[0];
      end
      ALU_SHR: begin
        y = a >> 1;
        c = a[0];
      end
      default: ;
    endcase
    return {c, y & mask};
  endfunction

endpackage

// File: rtl/alu_checker_if.sv
// Observed-transaction bus between an ALU monitor (master) and the checker (slave).
interface alu_checker_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic [WIDTH-1:0] y;
  logic             c;

  modport master (output in_valid, a, b, sel, y, c, input in_ready);
  modport slave  (input in_valid, a, b, sel, y, c, output in_ready);
endinterface

// File: rtl/alu_chk_pipe.sv
// Two-stage checker pipeline: stage 1 holds the transaction and expected {c,y},
// stage 2 holds the comparison result alongside the observed fields.
module alu_chk_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] y,
  input  logic             c,
  output logic             res_valid,
  output logic             res_mismatch,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic [2:0]       res_sel,
  output logic [WIDTH-1:0] res_y,
  output logic             res_c
);

  logic [MaxW:0]    ref_full;
  logic [WIDTH:0]   exp_cy;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_y_q;
  logic [2:0]       s1_sel_q;
  logic             s1_c_q;
  logic [WIDTH:0]   s1_exp_q;

  always_comb begin
    ref_full = alu_ref(MaxW'(a), MaxW'(b), sel, WIDTH);
    exp_cy   = {ref_full[MaxW], ref_full[WIDTH-1:0]};
  end

  // The model zeroes y bits above WIDTH; they carry no information here.
  if (WIDTH < MaxW) begin : g_unused
    logic unused_ref;
    assign unused_ref = ^ref_full[MaxW-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      res_valid  <= s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_q   <= a;
      s1_b_q   <= b;
      s1_sel_q <= sel;
      s1_y_q   <= y;
      s1_c_q   <= c;
      s1_exp_q <= exp_cy;
    end
    if (s1_valid_q) begin
      res_mismatch <= ({s1_c_q, s1_y_q} != s1_exp_q);
      res_a        <= s1_a_q;
      res_b        <= s1_b_q;
      res_sel      <= s1_sel_q;
      res_y        <= s1_y_q;
      res_c        <= s1_c_q;
    end
  end

endmodule

// File: rtl/alu_checker.sv
// ALU result checker: RUN/HALT control, saturating pass/fail counters and an
// optional first-mismatch capture record (enabled by ALU_CHK_CAPTURE_EN).
module alu_checker
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_checker_if.slave     bus,
  input  logic             halt_on_err,
  input  logic             resume,
  input  logic             clear,
  output logic             err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             halted,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_a,
  output logic [WIDTH-1:0] cap_b,
  output logic [2:0]       cap_sel,
  output logic [WIDTH-1:0] cap_y,
  output logic             cap_c
);

  logic             res_valid, res_mismatch, res_c;
  logic [WIDTH-1:0] res_a, res_b, res_y;
  logic [2:0]       res_sel;
  logic             upd, bad;
  chk_state_e       state_q;

  assign bus.in_ready = ~halted;

  alu_chk_pipe #(
    .WIDTH(WIDTH)
  ) u_pipe (
    .clk          (clk),
    .rst          (rst),
    .accept       (bus.in_valid & bus.in_ready),
    .a            (bus.a),
    .b            (bus.b),
    .sel          (bus.sel),
    .y            (bus.y),
    .c            (bus.c),
    .res_valid    (res_valid),
    .res_mismatch (res_mismatch),
    .res_a        (res_a),
    .res_b        (res_b),
    .res_sel      (res_sel),
    .res_y        (res_y),
    .res_c        (res_c)
  );

  // A clear on the same edge as a stage-2 result discards that result entirely.
  assign upd = res_valid & ~clear;
  assign bad = upd & res_mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      halted  <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bad && halt_on_err) begin
            state_q <= StHalt;
            halted  <= 1'b1;
          end
        end
        StHalt: begin
          if (resume) begin
            state_q <= StRun;
            halted  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err      <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      err <= bad;
      if (upd) begin
        if (res_mismatch) begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        end else begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef ALU_CHK_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cap_valid <= 1'b0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_sel   <= '0;
      cap_y     <= '0;
      cap_c     <= 1'b0;
    end else if (bad && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_a     <= res_a;
      cap_b     <= res_b;
      cap_sel   <= res_sel;
      cap_y     <= res_y;
      cap_c     <= res_c;
    end
  end
`else
  logic unused_cap;
  assign unused_cap = ^{res_a, res_b, res_sel, res_y, res_c};
  assign cap_valid  = 1'b0;
  assign cap_a      = '0;
  assign cap_b      = '0;
  assign cap_sel    = '0;
  assign cap_y      = '0;
  assign cap_c      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_checker.sv
// Directed and random checks for alu_checker (4-bit ALU), plus a narrow-counter
// instance for saturation.
module tb_alu_checker;

  localparam int unsigned W = 4;

`ifdef ALU_CHK_CAPTURE_EN
  localparam logic CapOn = 1'b1;
`else
  localparam logic CapOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, halt_on_err, resume, clear;
  logic err, halted, cap_valid, cap_c;
  logic [15:0] pass_cnt, fail_cnt;
  logic [W-1:0] cap_a, cap_b, cap_y;
  logic [2:0] cap_sel;

  logic s_err, s_halted, s_cap_valid, s_cap_c;
  logic [3:0] s_pass, s_fail;
  logic [W-1:0] s_cap_a, s_cap_b, s_cap_y;
  logic [2:0] s_cap_sel;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_pass = 0;
  int exp_fail = 0;

  alu_checker_if #(.WIDTH(W)) bus ();
  alu_checker_if #(.WIDTH(W)) sbus ();

  alu_checker #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .halt_on_err(halt_on_err), .resume(resume),
    .clear(clear), .err(err), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .halted(halted),
    .cap_valid(cap_valid), .cap_a(cap_a), .cap_b(cap_b), .cap_sel(cap_sel), .cap_y(cap_y),
    .cap_c(cap_c)
  );

  alu_checker #(.WIDTH(W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(sbus), .halt_on_err(1'b0), .resume(1'b0), .clear(1'b0),
    .err(s_err), .pass_cnt(s_pass), .fail_cnt(s_fail), .halted(s_halted),
    .cap_valid(s_cap_valid), .cap_a(s_cap_a), .cap_b(s_cap_b), .cap_sel(s_cap_sel),
    .cap_y(s_cap_y), .cap_c(s_cap_c)
  );

  always #5 clk = ~clk;

  // Independent 4-bit ALU model returning {c, y}.
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] s);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    case (s)
      3'd0:    return 5'(ai + bi);
      3'd1:    return {ai < bi, 4'((ai - bi + 16) % 16)};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a[3], a[2:0], 1'b0};
      default: return {a[0], 1'b0, a[3:1]};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                       input logic [3:0] y, input logic c);
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.sel = s; bus.y = y; bus.c = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt_on_err = 1'b0; resume = 1'b0; clear = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0; bus.y = '0; bus.c = 1'b0;
    sbus.in_valid = 1'b0; sbus.a = '0; sbus.b = '0; sbus.sel = '0; sbus.y = '0; sbus.c = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    n_checks++; if (pass_cnt !== 16'd0) $display("FAIL reset_pass: got %0d want 0", pass_cnt); else n_pass++;
    n_checks++; if (fail_cnt !== 16'd0) $display("FAIL reset_fail: got %0d want 0", fail_cnt); else n_pass++;
    n_checks++; if (cap_valid !== 1'b0) $display("FAIL reset_cap_valid: got %b want 0", cap_valid); else n_pass++;
    n_checks++; if ({cap_a, cap_b, cap_sel, cap_y, cap_c} !== '0) $display("FAIL reset_cap: got %h want 0", {cap_a, cap_b, cap_sel, cap_y, cap_c}); else n_pass++;
  endtask

  task automatic test_add_pass();
    drive(4'd3, 4'd4, 3'b000, 4'd7, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (pass_cnt !== 16'd0) $display("FAIL add_pass_latency: got %0d want 0", pass_cnt); else n_pass++;
    tick();
    exp_pass++;
    n_checks++; if (pass_cnt !== 16'(exp_pass)) $display("FAIL add_pass_cnt: got %0d want %0d", pass_cnt, exp_pass); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL add_pass_err: got %b want 0", err); else n_pass++;
    n_checks++; if (fail_cnt !== 16'(exp_fail)) $display("FAIL add_pass_fail: got %0d want %0d", fail_cnt, exp_fail); else n_pass++;
  endtask

  task automatic test_add_fail();
    drive(4'd15, 4'd1, 3'b000, 4'd0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (err !== 1'b0) $display("FAIL add_fail_early_err: got %b want 0", err); else n_pass++;
    tick();
    exp_fail++;
    n_checks++; if (err !== 1'b1) $display("FAIL add_fail_err: got %b want 1", err); else n_pass++;
    n_checks++; if (fail_cnt !== 16'(exp_fail)) $display("FAIL add_fail_cnt: got %0d want %0d", fail_cnt, exp_fail); else n_pass++;
    n_checks++; if (cap_valid !== CapOn) $display("FAIL add_fail_cap_valid: got %b want %b", cap_valid, CapOn); else n_pass++;
    n_checks++; if (cap_a !== (CapOn ? 4'd15 : 4'd0)) $display("FAIL add_fail_cap_a: got %0d want %0d", cap_a, CapOn ? 15 : 0); else n_pass++;
    n_checks++; if (cap_b !== (CapOn ? 4'd1 : 4'd0)) $display("FAIL add_fail_cap_b: got %0d want %0d", cap_b, CapOn ? 1 : 0); else n_pass++;
    n_checks++; if ({cap_sel, cap_y, cap_c} !== 8'd0) $display("FAIL add_fail_cap_rest: got %h want 0", {cap_sel, cap_y, cap_c}); else n_pass++;
    tick();
    n_checks++; if (err !== 1'b0) $display("FAIL add_fail_err_pulse: got %b want 0", err); else n_pass++;
  endtask

  // Back-to-back stream over every opcode; {a,b,sel,y,c,bad}
  task automatic test_ops();
    logic [16:0] vec [12];
    logic [3:0] va, vb, vy;
    logic [2:0] vs;
    logic vc, vbad;
    vec = '{{4'd3, 4'd5, 3'd1, 4'd14, 1'b1, 1'b0}, {4'd9, 4'd4, 3'd1, 4'd5, 1'b0, 1'b0},
            {4'd12, 4'd10, 3'd2, 4'd8, 1'b0, 1'b0}, {4'd12, 4'd3, 3'd3, 4'd15, 1'b0, 1'b0},
            {4'd12, 4'd10, 3'd4, 4'd6, 1'b0, 1'b0}, {4'd5, 4'd0, 3'd5, 4'd10, 1'b0, 1'b0},
            {4'd9, 4'd0, 3'd6, 4'd2, 1'b1, 1'b0}, {4'd9, 4'd0, 3'd7, 4'd4, 1'b1, 1'b0},
            {4'd9, 4'd8, 3'd0, 4'd1, 1'b1, 1'b0}, {4'd9, 4'd0, 3'd6, 4'd2, 1'b0, 1'b1},
            {4'd5, 4'd0, 3'd5, 4'd11, 1'b0, 1'b1}, {4'd12, 4'd10, 3'd2, 4'd8, 1'b1, 1'b1}};
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        {va, vb, vs, vy, vc, vbad} = vec[i];
        drive(va, vb, vs, vy, vc);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (i >= 2) begin
        {va, vb, vs, vy, vc, vbad} = vec[i-2];
        n_checks++; if (err !== vbad) $display("FAIL ops_err[%0d]: got %b want %b", i - 2, err, vbad); else n_pass++;
        if (vbad) exp_fail++; else exp_pass++;
      end
    end
    n_checks++; if (pass_cnt !== 16'(exp_pass)) $display("FAIL ops_pass: got %0d want %0d", pass_cnt, exp_pass); else n_pass++;
    n_checks++; if (fail_cnt !== 16'(exp_fail)) $display("FAIL ops_fail: got %0d want %0d", fail_cnt, exp_fail); else n_pass++;
    n_checks++; if ({cap_a, cap_y} !== (CapOn ? 8'hF0 : 8'h00)) $display("FAIL ops_cap_kept: got %h want %h", {cap_a, cap_y}, CapOn ? 8'hF0 : 8'h00); else n_pass++;
  endtask

  task automatic test_halt();
    halt_on_err = 1'b1;
    drive(4'd2, 4'd2, 3'b000, 4'd5, 1'b0);
    tick();
    drive(4'd2, 4'd2, 3'b000, 4'd4, 1'b0);
    resume = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    resume = 1'b0;
    exp_fail++;
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_enter: got %b want 1", halted); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL halt_ready: got %b want 0", bus.in_ready); else n_pass++;
    n_checks++; if (fail_cnt !== 16'(exp_fail)) $display("FAIL halt_fail: got %0d want %0d", fail_cnt, exp_fail); else n_pass++;
    tick();
    exp_pass++;
    n_checks++; if (pass_cnt !== 16'(exp_pass)) $display("FAIL halt_inflight_pass: got %0d want %0d", pass_cnt, exp_pass); else n_pass++;
    drive(4'd1, 4'd1, 3'b000, 4'd2, 1'b0);
    repeat (2) tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    n_checks++; if (pass_cnt !== 16'(exp_pass)) $display("FAIL halt_blocked: got %0d want %0d", pass_cnt, exp_pass); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_stays: got %b want 1", halted); else n_pass++;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL resume_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL resume_halted: got %b want 0", halted); else n_pass++;
    halt_on_err = 1'b0;
  endtask

  task automatic test_clear_collision();
    drive(4'd1, 4'd2, 3'b000, 4'd3, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_pass = 0; exp_fail = 0;
    n_checks++; if (pass_cnt !== 16'd0) $display("FAIL clear_match_pass: got %0d want 0", pass_cnt); else n_pass++;
    n_checks++; if (fail_cnt !== 16'd0) $display("FAIL clear_match_fail: got %0d want 0", fail_cnt); else n_pass++;
    drive(4'd1, 4'd2, 3'b000, 4'd4, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (fail_cnt !== 16'd0) $display("FAIL clear_mis_fail: got %0d want 0", fail_cnt); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL clear_mis_err: got %b want 0", err); else n_pass++;
    n_checks++; if (cap_valid !== 1'b0) $display("FAIL clear_cap_valid: got %b want 0", cap_valid); else n_pass++;
    drive(4'd7, 4'd2, 3'b001, 4'd5, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    exp_fail++;
    n_checks++; if (fail_cnt !== 16'(exp_fail)) $display("FAIL after_clear_fail: got %0d want %0d", fail_cnt, exp_fail); else n_pass++;
    n_checks++; if ({cap_valid, cap_a, cap_sel, cap_c} !== (CapOn ? 9'h1_7_3 : 9'h0)) $display("FAIL after_clear_cap: got %h want %h", {cap_valid, cap_a, cap_sel, cap_c}, CapOn ? 9'h173 : 9'h0); else n_pass++;
  endtask

  task automatic test_reset_inflight();
    drive(4'd3, 4'd3, 3'b000, 4'd0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pass = 0; exp_fail = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (err !== 1'b0) $display("FAIL rst_inflight_err[%0d]: got %b want 0", i, err); else n_pass++;
      n_checks++; if ({pass_cnt, fail_cnt} !== 32'd0) $display("FAIL rst_inflight_cnt[%0d]: got %h want 0", i, {pass_cnt, fail_cnt}); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int want;
    for (int i = 0; i < 19; i++) begin
      if (i < 17) begin
        sbus.in_valid = 1'b1; sbus.a = 4'd1; sbus.b = 4'd1; sbus.sel = 3'b000;
        sbus.y = 4'd0; sbus.c = 1'b0;
      end else begin
        sbus.in_valid = 1'b0;
      end
      tick();
      if (i >= 2) begin
        want = (i - 1 > 15) ? 15 : i - 1;
        n_checks++; if (s_fail !== 4'(want)) $display("FAIL sat_fail[%0d]: got %0d want %0d", i, s_fail, want); else n_pass++;
        n_checks++; if (s_err !== 1'b1) $display("FAIL sat_err[%0d]: got %b want 1", i, s_err); else n_pass++;
      end
    end
    n_checks++; if (s_pass !== 4'd0) $display("FAIL sat_pass: got %0d want 0", s_pass); else n_pass++;
  endtask

  task automatic test_random();
    int inj = 0;
    int errs = 0;
    logic [3:0] a, b;
    logic [2:0] s;
    logic [4:0] cy;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      a = 4'($urandom); b = 4'($urandom); s = 3'($urandom);
      cy = model(a, b, s);
      if ($urandom_range(0, 9) == 0) begin
        cy = cy ^ (5'd1 << $urandom_range(0, 4));
        inj++;
      end
      drive(a, b, s, cy[3:0], cy[4]);
      tick();
      if (err) errs++;
    end
    bus.in_valid = 1'b0;
    repeat (2) begin
      tick();
      if (err) errs++;
    end
    tick();
    n_checks++; if (int'(pass_cnt) + int'(fail_cnt) !== 10000) $display("FAIL rand_total: got %0d want 10000", int'(pass_cnt) + int'(fail_cnt)); else n_pass++;
    n_checks++; if (int'(fail_cnt) !== inj) $display("FAIL rand_fail: got %0d want %0d", fail_cnt, inj); else n_pass++;
    n_checks++; if (errs !== inj) $display("FAIL rand_err_pulses: got %0d want %0d", errs, inj); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_pass();
    test_add_fail();
    test_ops();
    test_halt();
    test_clear_collision();
    test_reset_inflight();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
